fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the LEGv8 datapath. Holds the program counter, issues one word request at a time to instruction memory over a valid/ready handshake, and buffers the returned instruction for decode. Decode drives the sign-extension path from this instruction. The sign-extended, already-shifted branch offset comes back into this block to redirect the PC for B/CB branches, and BR supplies an absolute register target.

## Interface
Parameters:
- RESET_PC, 64'h0, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_req_valid  out  1  request to instruction memory
- imem_req_addr  out  64  registered request word address
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  response data valid
- imem_resp_data  in  32  instruction word
- instr_valid  out  1  buffered instruction available to decode
- instr  out  32  buffered instruction
- instr_pc  out  64  address of the buffered instruction
- instr_ready  in  1  decode consumes instruction
- redirect_valid  in  1  taken branch / jump this cycle
- redirect_is_reg  in  1  1: BR absolute target; 0: PC-relative
- redirect_base  in  64  PC of the branch instruction
- extended_address  in  64  sign-extended, <<2 offset from the extension unit
- redirect_reg_target  in  64  register value for BR
- misalign_err  out  1  one-cycle pulse: target bits [1:0] were non-zero
- pc  out  64  current fetch PC

## Operation
- States: IDLE, REQ, WAIT, HOLD. A single drop flag marks an in-flight response to be discarded.
- Reset values: pc=RESET_PC, state=IDLE, imem_req_valid=0, imem_req_addr=0, instr_valid=0, instr=0, instr_pc=0, misalign_err=0, drop=0.
- IDLE: one cycle, then REQ. imem_req_addr<=pc on entry to REQ.
- REQ: imem_req_valid=1. imem_req_addr is held stable until imem_req_ready. On accept, go to WAIT.
- WAIT: on imem_resp_valid with drop=0: instr<=data, instr_pc<=pc, pc<=pc+4 (mod 2^64), instr_valid<=1, go to HOLD. With drop=1: clear drop, go to REQ, no capture.
- HOLD: instr_valid=1. On instr_ready: instr_valid<=0, go to REQ.
- Redirect target: redirect_is_reg ? redirect_reg_target : redirect_base+extended_address (64-bit wrap). Bits [1:0] are forced to 0 when loaded into pc. misalign_err pulses the next cycle if they were non-zero.
- Redirect handling by state:
  - IDLE: pc<=target.
  - REQ (accepted or not): pc<=target, drop<=1. The pending request completes with its original address.
  - WAIT: pc<=target, drop<=1. If imem_resp_valid is in the same cycle, the response is discarded, drop stays 0, and the next state is REQ.
  - HOLD: pc<=target, instr_valid<=0, go to REQ. If instr_ready is in the same cycle, the handshake still counts as consumed.
- Responses arriving outside WAIT are ignored.
- reset overrides all inputs, including a mid-transaction redirect. Any in-flight response after reset is ignored because the state is IDLE/REQ with no outstanding request.

## Timing
- Request accepted at cycle N, response at N+k (k≥1) → instr_valid high at N+k+1.
- Consume at cycle M → imem_req_valid high at M+1.
- Zero-wait memory: one instruction every 3 cycles.
- Redirect at cycle R → pc=target at R+1. If no request is outstanding, imem_req_addr=target by R+1.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - adds outputs fetched_cnt[31:0] and flushed_cnt[31:0], both reset to 0 and wrapping;
  - fetched_cnt increments on every captured response;
  - flushed_cnt increments on every dropped response and every HOLD invalidation by redirect.
- Not defined: neither port nor counter logic exists.

## Test plan
- Reset with RESET_PC=64'h40, zero-wait memory, instr_ready tied 1 → request addresses 0x40, 0x44, 0x48; instr_pc matches; instr_valid high every 3rd cycle.
- Redirect during HOLD, PC-relative, base=0x100, extended_address=64'hFFFF_FFFF_FFFF_FFF8 → held instruction invalidated next cycle; next request address 0xF8.
- Redirect during WAIT, memory latency 3 → stale response is not presented (instr_valid stays 0); next request goes to the target.
- Redirect coincident with imem_resp_valid → response discarded, no extra dropped response later, request to target next cycle.
- BR redirect with redirect_reg_target=0x203 → pc=0x200, misalign_err pulses one cycle.
- With FETCH_PERF_CNT_EN: 5 fetched instructions and 2 flushes → fetched_cnt=5, flushed_cnt=2; reset mid-run clears both to 0.

Source files
------------

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch: PC register, single-outstanding imem request, one-entry instruction buffer.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic        redirect_is_reg,
    input  logic [63:0] redirect_base,
    input  logic [63:0] extended_address,
    input  logic [63:0] redirect_reg_target,
    output logic        misalign_err,
    output logic [63:0] pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetched_cnt,
    output logic [31:0] flushed_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state, state_nxt;
    logic        drop, drop_nxt;
    logic [63:0] pc_nxt;
    logic        req_valid_nxt;
    logic [63:0] req_addr_nxt;
    logic        instr_valid_nxt;
    logic [31:0] instr_nxt;
    logic [63:0] instr_pc_nxt;
    logic        misalign_nxt;
    logic        enter_req;
    logic [63:0] target_raw;
    logic [63:0] target;

    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

    always_comb begin
        target_raw      = redirect_is_reg ? redirect_reg_target : redirect_base + extended_address;
        target          = word_align(target_raw);
        state_nxt       = state;
        drop_nxt        = drop;
        pc_nxt          = pc;
        req_valid_nxt   = imem_req_valid;
        req_addr_nxt    = imem_req_addr;
        instr_valid_nxt = instr_valid;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;
        misalign_nxt    = redirect_valid && (target_raw[1:0] != 2'b00);
        enter_req       = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = REQ;
                enter_req = 1'b1;
                if (redirect_valid) pc_nxt = target;
            end
            REQ: begin
                // The issued address stays put; a redirect only marks its response stale.
                if (redirect_valid) begin
                    pc_nxt   = target;
                    drop_nxt = 1'b1;
                end
                if (imem_req_ready) begin
                    req_valid_nxt = 1'b0;
                    state_nxt     = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (drop || redirect_valid) begin
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                        enter_req = 1'b1;
                        if (redirect_valid) pc_nxt = target;
                    end else begin
                        instr_nxt       = imem_resp_data;
                        instr_pc_nxt    = pc;
                        pc_nxt          = pc + 64'd4;
                        instr_valid_nxt = 1'b1;
                        state_nxt       = HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_nxt   = target;
                    drop_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid || instr_ready) begin
                    instr_valid_nxt = 1'b0;
                    state_nxt       = REQ;
                    enter_req       = 1'b1;
                    if (redirect_valid) pc_nxt = target;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (enter_req) begin
            req_valid_nxt = 1'b1;
            req_addr_nxt  = pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            drop           <= 1'b0;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= 64'h0;
            instr_valid    <= 1'b0;
            instr          <= 32'h0;
            instr_pc       <= 64'h0;
            misalign_err   <= 1'b0;
        end else begin
            state          <= state_nxt;
            drop           <= drop_nxt;
            pc             <= pc_nxt;
            imem_req_valid <= req_valid_nxt;
            imem_req_addr  <= req_addr_nxt;
            instr_valid    <= instr_valid_nxt;
            instr          <= instr_nxt;
            instr_pc       <= instr_pc_nxt;
            misalign_err   <= misalign_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetched_inc;
    logic flushed_inc;

    // A flush is either a discarded memory response or a buffered instruction killed by redirect.
    always_comb begin
        fetched_inc = (state == WAIT) && imem_resp_valid && !drop && !redirect_valid;
        flushed_inc = ((state == WAIT) && imem_resp_valid && (drop || redirect_valid)) ||
                      ((state == HOLD) && redirect_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_cnt <= 32'h0;
            flushed_cnt <= 32'h0;
        end else begin
            if (fetched_inc) fetched_cnt <= fetched_cnt + 32'd1;
            if (flushed_inc) flushed_cnt <= flushed_cnt + 32'd1;
        end
    end
`endif

endmodule
